prog_sequencer: RTL and testbench

Parametrised successor to the fixed 6-bit program counter and jump lookup table pair. It sequences instruction addresses with four jump modes, a runtime-programmable jump table, a call/return stack and a stall input. It also registers the halt/Done detection. It sits between Ctrl/ALU (branch request) and InstROM (address), and drives the top-level Done flag.

---
 rtl/prog_sequencer_if.sv | 37 +++
 rtl/prog_sequencer.sv | 157 +++++++++++++++
 tb/tb_prog_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_sequencer_if : branch-request, jump-table write and status bundle      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface prog_sequencer_if #(
  parameter int PC_W    = 6,
  parameter int PTR_W   = 3,
  parameter int OFF_W   = 5,
  parameter int STACK_D = 4
);
  localparam int C_DEPTH_W = $clog2(STACK_D + 1);

  logic                 stall;
  logic                 Jen;
  logic [1:0]           Jmode;
  logic [PTR_W-1:0]     Jptr;
  logic [OFF_W-1:0]     Joff;
  logic                 lut_we;
  logic [PTR_W-1:0]     lut_waddr;
  logic [PC_W-1:0]      lut_wdata;
  logic [PC_W-1:0]      PC;
  logic                 Done;
  logic                 stack_err;
  logic [C_DEPTH_W-1:0] depth;

  modport master (
    output stall, Jen, Jmode, Jptr, Joff, lut_we, lut_waddr, lut_wdata,
    input  PC, Done, stack_err, depth
  );

  modport slave (
    input  stall, Jen, Jmode, Jptr, Joff, lut_we, lut_waddr, lut_wdata,
    output PC, Done, stack_err, depth
  );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_sequencer : program counter with jump table, call stack and halt      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module prog_sequencer #(
  parameter int PC_W      = 6,
  parameter int PTR_W     = 3,
  parameter int OFF_W     = 5,
  parameter int STACK_D   = 4,
  parameter int HALT_ADDR = 43
) (
  input wire              Clk,
  input wire              start,
  prog_sequencer_if.slave bus
);
  localparam int c_DEPTH_W = $clog2(STACK_D + 1);
  localparam int c_SIDX_W  = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int c_LUT_N   = 2 ** PTR_W;

  localparam logic [PC_W-1:0]      c_HALT     = PC_W'(HALT_ADDR);
  localparam logic [c_DEPTH_W-1:0] c_FULL     = c_DEPTH_W'(STACK_D);
  localparam logic [1:0]           c_JM_ABS   = 2'b00;
  localparam logic [1:0]           c_JM_REL   = 2'b01;
  localparam logic [1:0]           c_JM_CALL  = 2'b10;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [PC_W-1:0]       r_pc, w_pc_nxt;
  logic [c_DEPTH_W-1:0]  r_depth, w_depth_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_push;

  logic [PC_W-1:0]       r_lut   [c_LUT_N];
  logic [PC_W-1:0]       r_stack [STACK_D];

  logic [PC_W-1:0]       w_off_ext;
  logic [PC_W-1:0]       w_pc_inc;
  logic [PC_W-1:0]       w_lut_rd;
  logic [PC_W-1:0]       w_stack_top;
  logic [c_DEPTH_W-1:0]  w_depth_dec;
  logic [c_SIDX_W-1:0]   w_push_idx;
  logic [c_SIDX_W-1:0]   w_top_idx;

  generate
    if (OFF_W >= PC_W) begin : g_off_trunc
      assign w_off_ext = bus.Joff[PC_W-1:0];
    end else begin : g_off_sext
      assign w_off_ext = {{(PC_W - OFF_W){bus.Joff[OFF_W-1]}}, bus.Joff};
    end
  endgenerate

  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_lut_rd    = r_lut[bus.Jptr];
  assign w_depth_dec = r_depth - c_DEPTH_W'(1);
  // Push slot is the current depth, top of stack sits one below it.
  assign w_push_idx  = r_depth[c_SIDX_W-1:0];
  assign w_top_idx   = w_depth_dec[c_SIDX_W-1:0];
  assign w_stack_top = r_stack[w_top_idx];

  always_ff @(posedge Clk or posedge start) begin
    if (start) begin
      for (int i = 0; i < c_LUT_N; i++) begin
        r_lut[i] <= '0;
      end
    end else if (bus.lut_we) begin
      r_lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // Entries above depth are never read, so the storage needs no reset.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  always_ff @(posedge Clk or posedge start) begin
    if (start) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_depth <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!bus.stall) begin
          if (r_pc == c_HALT) begin
            w_state_nxt = S_HALT;
            w_done_nxt  = 1'b1;
          end else if (!bus.Jen) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            case (bus.Jmode)
              c_JM_ABS: w_pc_nxt = w_lut_rd;
              c_JM_REL: w_pc_nxt = r_pc + w_off_ext;
              c_JM_CALL: begin
                if (r_depth == c_FULL) begin
                  w_state_nxt = S_FAULT;
                  w_err_nxt   = 1'b1;
                end else begin
                  w_push      = 1'b1;
                  w_pc_nxt    = w_lut_rd;
                  w_depth_nxt = r_depth + c_DEPTH_W'(1);
                end
              end
              default: begin
                if (r_depth == '0) begin
                  w_state_nxt = S_FAULT;
                  w_err_nxt   = 1'b1;
                end else begin
                  w_pc_nxt    = w_stack_top;
                  w_depth_nxt = w_depth_dec;
                end
              end
            endcase
          end
        end
      end
      S_HALT, S_FAULT: begin
      end
      default: begin
        w_state_nxt = S_FAULT;
        w_err_nxt   = 1'b1;
      end
    endcase
  end

  assign bus.PC        = r_pc;
  assign bus.Done      = r_done;
  assign bus.stack_err = r_err;
  assign bus.depth     = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_sequencer : vector table and scoreboard bench for prog_sequencer   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_prog_sequencer;
  logic Clk;
  logic start;

  prog_sequencer_if #(.PC_W(6), .PTR_W(3), .OFF_W(5), .STACK_D(4)) bus ();

  prog_sequencer #(
    .PC_W(6), .PTR_W(3), .OFF_W(5), .STACK_D(4), .HALT_ADDR(43)
  ) u_dut (
    .Clk  (Clk),
    .start(start),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       jen;
    logic [1:0] jmode;
    logic [2:0] jptr;
    logic [4:0] joff;
    logic       we;
    logic [2:0] waddr;
    logic [5:0] wdata;
    logic [5:0] pc;
    logic [2:0] depth;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(input logic rst, input logic stall, input logic jen,
                             input logic [1:0] jmode, input logic [2:0] jptr,
                             input logic [4:0] joff, input logic we,
                             input logic [2:0] waddr, input logic [5:0] wdata,
                             input logic [5:0] pc, input logic [2:0] depth,
                             input logic done, input logic err);
    vec_t x;
    x.rst = rst; x.stall = stall; x.jen = jen; x.jmode = jmode; x.jptr = jptr;
    x.joff = joff; x.we = we; x.waddr = waddr; x.wdata = wdata;
    x.pc = pc; x.depth = depth; x.done = done; x.err = err;
    return x;
  endfunction

  function automatic vec_t idle(input logic [5:0] pc, input logic [2:0] depth,
                                input logic done, input logic err);
    return v(0, 0, 0, 2'b00, 3'd0, 5'd0, 0, 3'd0, 6'd0, pc, depth, done, err);
  endfunction

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic drive(input vec_t x);
    bus.stall     = x.stall;
    bus.Jen       = x.jen;
    bus.Jmode     = x.jmode;
    bus.Jptr      = x.jptr;
    bus.Joff      = x.joff;
    bus.lut_we    = x.we;
    bus.lut_waddr = x.waddr;
    bus.lut_wdata = x.wdata;
  endtask

  task automatic check_state(input string tag, input logic [5:0] pc,
                             input logic [2:0] depth, input logic done, input logic err);
    chk({tag, ".pc"},    8'(bus.PC),        8'(pc));
    chk({tag, ".depth"}, 8'(bus.depth),     8'(depth));
    chk({tag, ".done"},  8'(bus.Done),      8'(done));
    chk({tag, ".err"},   8'(bus.stack_err), 8'(err));
  endtask

  task automatic step(input vec_t x, input string tag);
    vec_t e;
    drive(x);
    sb.push_back(x);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check_state(tag, e.pc, e.depth, e.done, e.err);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    start = 1'b1;
    drive(idle(6'd0, 3'd0, 0, 0));
    #2;
    check_state(tag, 6'd0, 3'd0, 0, 0);
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Raises start between clock edges and checks the clear is immediate.
  task automatic async_reset_check(input string tag);
    #2;
    start = 1'b1;
    #1;
    check_state(tag, 6'd0, 3'd0, 0, 0);
    @(negedge Clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b1;
    drive(idle(6'd0, 3'd0, 0, 0));

    // Free run to the halt address, then verify HALT ignores everything.
    do_reset("a_rst");
    for (int i = 1; i <= 43; i++) begin
      step(idle(6'(i), 3'd0, 0, 0), $sformatf("a_run%0d", i));
    end
    step(idle(6'd43, 3'd0, 1, 0), "a_halt");
    for (int i = 0; i < 10; i++) begin
      step(v(0, i[0], 1, 2'(i % 4), 3'd1, 5'd5, 0, 3'd0, 6'd0, 6'd43, 3'd0, 1, 0),
           $sformatf("a_hold%0d", i));
    end
    async_reset_check("a_async");

    // rst stall jen mode ptr joff we waddr wdata | pc depth done err
    vecs.push_back(v(1, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd1,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd2,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd3,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      1, 3'd2, 6'd20, 6'd4,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      1, 3'd1, 6'd30, 6'd5,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b00, 3'd2, 5'd0,      0, 3'd0, 6'd0,  6'd20, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b00, 3'd3, 5'd0,      1, 3'd3, 6'd9,  6'd0,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b00, 3'd3, 5'd0,      0, 3'd0, 6'd0,  6'd9,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b00001,  0, 3'd0, 6'd0,  6'd10, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b11101,  0, 3'd0, 6'd0,  6'd7,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b00000,  0, 3'd0, 6'd0,  6'd7,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b10111,  0, 3'd0, 6'd0,  6'd62, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b00100,  0, 3'd0, 6'd0,  6'd2,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd3,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd4,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd31, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd32, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd33, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd5,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b00111,  0, 3'd0, 6'd0,  6'd12, 3'd0, 0, 0));
    vecs.push_back(v(0, 1, 1, 2'b10, 3'd1, 5'd0,      1, 3'd4, 6'd50, 6'd12, 3'd0, 0, 0));
    vecs.push_back(v(0, 1, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd12, 3'd0, 0, 0));
    vecs.push_back(v(0, 1, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd12, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd2, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd3, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd31, 3'd2, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd31, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd13, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b00, 3'd4, 5'd0,      0, 3'd0, 6'd0,  6'd50, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd51, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b01, 3'd0, 5'b01100,  0, 3'd0, 6'd0,  6'd63, 3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd0,  3'd0, 0, 0));
    // Table cleared by reset, then call overflow into FAULT.
    vecs.push_back(v(1, 0, 1, 2'b00, 3'd2, 5'd0,      0, 3'd0, 6'd0,  6'd0,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      1, 3'd1, 6'd30, 6'd1,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd2,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd1, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd2, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd3, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd4, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b10, 3'd1, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd4, 0, 1));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd4, 0, 1));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd30, 3'd4, 0, 1));
    // Return underflow.
    vecs.push_back(v(1, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd1,  3'd0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2'b11, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd1,  3'd0, 0, 1));
    vecs.push_back(v(0, 0, 0, 2'b00, 3'd0, 5'd0,      0, 3'd0, 6'd0,  6'd1,  3'd0, 0, 1));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset($sformatf("v%0d_rst", i));
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Clear FAULT between edges, then confirm the counter restarts.
    async_reset_check("d_async");
    step(idle(6'd1, 3'd0, 0, 0), "d_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
